// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU datapath among NREQ requesters.
// Operands are registered into the ALU and result/flags registered out; one op in flight.
module alu_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = $clog2(NREQ),
  parameter int unsigned OPW  = 4,
  parameter int unsigned DW   = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][OPW-1:0] req_op,
  input  logic [NREQ-1:0][DW-1:0]  req_a,
  input  logic [NREQ-1:0][DW-1:0]  req_b,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ack,
  output logic [DW-1:0]            rsp_out,
  output logic                     rsp_negative,
  output logic                     rsp_overflow,
  output logic                     rsp_zero,
  output logic [OPW-1:0]           alu_opcode,
  output logic [DW-1:0]            alu_portA,
  output logic [DW-1:0]            alu_portB,
  input  logic [DW-1:0]            alu_outPort,
  input  logic                     alu_negative,
  input  logic                     alu_overflow,
  input  logic                     alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [DW-1:0]     out_q, out_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   valid_q, valid_d;

  logic              found_c;
  logic [PW-1:0]     pick_c;
  logic [PW-1:0]     cand_c;

  // Round-robin search: first asserted req at or above the pointer, wrapping.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_c = PW'((32'(ptr_q) + i) % NREQ);
      if (!found_c && req[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    gnt_d   = '0;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          win_d         = pick_c;
          op_d          = req_op[pick_c];
          a_d           = req_a[pick_c];
          b_d           = req_b[pick_c];
          gnt_d[pick_c] = 1'b1;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_d          = alu_outPort;
        neg_d          = alu_negative;
        ovf_d          = alu_overflow;
        zero_d         = alu_zero;
        valid_d        = '0;
        valid_d[win_q] = 1'b1;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        // Only the winner's ack releases the result; the completer drops to lowest priority.
        if (rsp_ack[win_q]) begin
          valid_d = '0;
          ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      gnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = valid_q;
  assign rsp_out      = out_q;
  assign rsp_negative = neg_q;
  assign rsp_overflow = ovf_q;
  assign rsp_zero     = zero_q;
  assign alu_opcode   = op_q;
  assign alu_portA    = a_q;
  assign alu_portB    = b_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU datapath (alu_if, alu modport) between NREQ requesters: the execute stage, the branch-compare unit and the multi-cycle mult/div sequencer.
- Arbitration is round-robin; one operation is in flight at a time.
- Operands are registered before they reach the ALU, and the flags and result are registered after it, so the ALU sits between two flop stages.
- The result is held per winner until that requester acknowledges it.

Parameters:
- NREQ, default 2: number of requesters, minimum 2, maximum 4.
- PW, default $clog2(NREQ): width of the round-robin pointer and the winner index.

Ports:
- CLK, input, 1: single clock, rising edge.
- nRST, input, 1: asynchronous, active-low reset.
- req, input, NREQ: per-requester request.
- req_op, input, NREQ x aluop_t: per-requester opcode.
- req_a, input, NREQ x word_t: per-requester operand A.
- req_b, input, NREQ x word_t: per-requester operand B.
- gnt, output, NREQ: one-hot grant, one-cycle pulse.
- rsp_valid, output, NREQ: one-hot, result valid for that requester.
- rsp_ack, input, NREQ: requester consumes its result.
- rsp_out, output, word_t: registered ALU result.
- rsp_negative, output, 1: registered ALU flag.
- rsp_overflow, output, 1: registered ALU flag.
- rsp_zero, output, 1: registered ALU flag.
- alu_opcode, output, aluop_t: to alu_if.opcode.
- alu_portA, output, word_t: to alu_if.portA.
- alu_portB, output, word_t: to alu_if.portB.
- alu_outPort, input, word_t: from alu_if.outPort.
- alu_negative, input, 1: from alu_if.negative.
- alu_overflow, input, 1: from alu_if.overflow.
- alu_zero, input, 1: from alu_if.zero.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset values:
  - State goes to IDLE; the round-robin pointer goes to 0; the winner register goes to 0.
  - gnt, rsp_valid, rsp_out and all rsp flags are 0.
  - alu_opcode, alu_portA and alu_portB are driven from the operand registers, which reset to 0.
- State IDLE:
  - req is sampled only in this state. The winner is the first asserted req, searching from the pointer upward with wrap from NREQ-1 to 0.
  - If any req is asserted, latch the winner index and its req_op, req_a and req_b, then go to EXEC.
  - If no req is asserted, stay in IDLE.
- State EXEC (one cycle):
  - gnt[winner] is 1 for this cycle only.
  - The ALU ports are driven from the latched registers.
  - At the end of the cycle, capture alu_outPort and the three flags into the rsp registers, then go to RESP.
- State RESP:
  - rsp_valid[winner] is 1, and rsp_out and the flags are held stable.
  - When rsp_ack[winner] is 1: pointer becomes (winner+1) mod NREQ, rsp_valid is cleared, state goes to IDLE.
  - Otherwise stay in RESP indefinitely; there is no timeout.
- Latency: req asserted in IDLE at cycle N, gnt at N+1, rsp_valid from N+2. With ack at N+2, the arbiter is back in IDLE at N+3. Best-case throughput is one operation per 3 cycles.
- Requester rules:
  - Hold req, req_op, req_a and req_b stable until gnt is seen.
  - Deassert req by the cycle after gnt unless issuing a new operation; a req still high when IDLE is re-entered is a new request.
  - rsp_ack may be asserted in the same cycle rsp_valid rises.
- Ignored inputs:
  - rsp_ack from a non-winner, or any rsp_ack outside RESP, is ignored.
  - req changes outside IDLE are ignored.
- Fairness: a requester that just completed has lowest priority at the next arbitration. With all NREQ requesters continuously asserting, each is served once per NREQ operations.
- Arithmetic: none inside the block. Result and flags are exactly the ALU outputs for the latched operands; no width changes.
- Reset mid-operation: the asynchronous return to IDLE drops gnt and rsp_valid immediately. The in-flight result is discarded and the pointer returns to 0.
- Opcodes are passed through unchecked. Illegal opcodes yield whatever the ALU produces.

Test Plan:
- Single request: only req[0], ALU_ADD, A=5, B=7 -> gnt[0] at N+1; rsp_valid[0] at N+2; rsp_out=12; zero=0, negative=0, overflow=0.
- Flags via subtract: req[1], ALU_SUB, A=3, B=3 -> rsp_out=0, zero=1. Then ALU_ADD, A=0x7FFFFFFF, B=1 -> rsp_out=0x80000000, overflow=1, negative=1.
- Fairness: req[0] and req[1] held high continuously, ack immediate -> grants alternate 0,1,0,1 starting with 0 after reset; gnt pulses spaced 3 cycles.
- Delayed ack: hold rsp_ack[winner]=0 for 5 cycles -> rsp_valid and rsp_out stable for all 5 cycles, no gnt issued, a new req[1] is not served until the cycle after ack.
- Wrong-port ack: winner 0 in RESP, pulse rsp_ack[1] -> no state change, rsp_valid[0] stays 1.
- Reset in EXEC and in RESP: assert nRST=0 -> gnt, rsp_valid and rsp_out go to 0 without waiting for a clock edge. After release, the next arbitration with both req high grants requester 0.
